tt_sweep_checker: RTL and testbench
===================================

// Module: tt_sweep_checker
// PURPOSE
//  Synthesizable driver/checker for small combinational logic circuits.
//  Sweeps every input vector 0..2^N_IN-1 into the DUT and waits SETTLE cycles.
//  Samples the DUT outputs and compares them against an expected truth table.
//  Reports the number of mismatches, the first failing vector and pass/done.
//  Sits beside a logic-circuit DUT for on-chip/FPGA self-test.
// PARAMETERS
//  N_IN    2  DUT input width; the sweep covers 2^N_IN vectors (1..8)
//  N_OUT   3  DUT output width compared per vector (1..16)
//  SETTLE  2  cycles vec_out is held before sampling (>=1)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous, active-low reset
//  start      in   1                  begin a sweep; sampled only in IDLE
//  exp_table  in   N_OUT*2^N_IN       expected outputs; vector v at [v*N_OUT +: N_OUT]
//  dut_out    in   N_OUT              DUT outputs returned to the checker
//  vec_out    out  N_IN               stimulus vector driven to the DUT inputs
//  busy       out  1                  sweep in progress
//  sample_vld out  1                  1-cycle pulse: sample_vec/sample_val updated
//  sample_vec out  N_IN               vector just sampled
//  sample_val out  N_OUT              dut_out captured for sample_vec
//  done       out  1                  1-cycle pulse at the end of a sweep
//  pass       out  1                  last sweep had zero mismatches; held until next start
//  err_cnt    out  N_IN+1             mismatches in the current/last sweep
//  fail_vec   out  N_IN               first mismatching vector; meaningful when err_cnt!=0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; every output is 0. Outputs stay 0 while rst_n is low.
//  - All outputs are registered. States: IDLE, SETTLE, SAMPLE.
//  - IDLE: busy=0. start=1 at an edge: vec_out<=0, cnt<=0, err_cnt<=0, pass<=0,
//    fail_vec<=0, busy<=1 -> SETTLE.
//  - SETTLE: cnt increments each edge. At the edge where cnt==SETTLE-1 -> SAMPLE.
//    vec_out is stable for the whole of SETTLE and SAMPLE.
//  - SAMPLE edge:
//    - capture sample_val<=dut_out, sample_vec<=vec_out, sample_vld<=1 for 1 cycle.
//    - mismatch = (dut_out != exp_table slice of vec_out).
//    - On mismatch: err_cnt++. If err_cnt was 0, fail_vec<=vec_out.
//    - If vec_out != 2^N_IN-1: vec_out++, cnt<=0 -> SETTLE.
//    - Else: -> IDLE, busy<=0, done<=1 for 1 cycle, vec_out<=0,
//      pass<=(no mismatch in the whole sweep, including this vector).
//  - Latency: SETTLE+1 edges per vector. done is high in the cycle after edge
//    2^N_IN*(SETTLE+1) counted from the start edge (the start edge is edge 0).
//  - err_cnt cannot overflow: width N_IN+1 holds 2^N_IN.
//  - start while busy: ignored, with no effect on the sweep.
//  - start high in the done cycle: accepted, because the state is IDLE.
//    A new sweep begins and clears pass/err_cnt/fail_vec on that edge.
//  - start held high continuously: back-to-back sweeps with no gap cycle.
//  - Reset mid-sweep: immediate abort to the reset values. No done is generated.
//    The next start begins again at vector 0.
//  - exp_table is sampled only at SAMPLE edges. It must be stable while busy=1.
// TESTING
//  1. rst_n=0 for 3 cycles with start=1
//     -> all outputs 0; after release with start=0, IDLE holds and vec_out=0.
//  2. N_IN=2, N_OUT=1, DUT=AND, exp_table=4'b1000, pulse start
//     -> vec_out 0,1,2,3, each held 3 cycles; sample_vec 0..3;
//        done after edge 12; pass=1, err_cnt=0.
//  3. Same as 2 with exp_table=4'b1001 -> mismatch at vec 0 only:
//     err_cnt=1, fail_vec=0, pass=0.
//     With exp_table=4'b0111 -> err_cnt=4, fail_vec=0.
//  4. Pulse start again 5 cycles into a sweep -> ignored; done still after edge 12.
//     Then raise start in the done cycle -> a new sweep starts, vec_out=0, busy=1.
//  5. Drop rst_n while sample_vec=2 -> outputs 0 asynchronously, no done pulse.
//     After release, start -> full sweep from vec 0 with correct pass.
//  6. N_IN=3, N_OUT=2, SETTLE=1, DUT=identity on 2 LSBs, matching table
//     -> done after edge 16, pass=1; vec_out changes only on SAMPLE edges.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive truth-table sweep driver and checker
// Drives every input vector to a combinational DUT, samples its outputs and scores them against exp_table.
module tt_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_OUT*(1<<N_IN)-1:0]    exp_table,
  input  logic [N_OUT-1:0]              dut_out,
  output logic [N_IN-1:0]               vec_out,
  output logic                          busy,
  output logic                          sample_vld,
  output logic [N_IN-1:0]               sample_vec,
  output logic [N_OUT-1:0]              sample_val,
  output logic                          done,
  output logic                          pass,
  output logic [N_IN:0]                 err_cnt,
  output logic [N_IN-1:0]               fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [N_OUT-1:0] exp_cur;
  logic            mismatch;
  logic            last_vec;

  assign exp_cur  = exp_table[vec_out*N_OUT +: N_OUT];
  assign mismatch = (dut_out != exp_cur);
  assign last_vec = (vec_out == LAST_VEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == CNT_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = last_vec ? ST_IDLE : ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // vec_out only moves on SAMPLE edges, so the DUT sees it steady through settle and sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out    <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      sample_vld <= 1'b0;
      sample_vec <= '0;
      sample_val <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
    end else begin
      sample_vld <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec_out  <= '0;
            cnt      <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            fail_vec <= '0;
            busy     <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          sample_val <= dut_out;
          sample_vec <= vec_out;
          sample_vld <= 1'b1;
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) begin
              fail_vec <= vec_out;
            end
          end
          cnt <= '0;
          if (!last_vec) begin
            vec_out <= vec_out + 1'b1;
          end else begin
            vec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_cnt == '0) && !mismatch;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - randomized and directed bench for tt_sweep_checker
// Instance a (2 in, 1 out, settle 2) is scored every cycle against a model; instance b (3 in, 2 out, settle 1) per sweep.
module tb_tt_sweep_checker;

  localparam int SA = 2;

  logic clk = 0;
  logic rst_a = 1, start_a = 0, rst_b = 1, start_b = 0;
  logic [3:0] exp_a = 4'b1000, flip_a = 4'b0000;
  logic [0:0] dut_out_a;
  logic [1:0] vec_a, svec_a, fail_a;
  logic [0:0] sval_a;
  logic [2:0] err_a;
  logic busy_a, vld_a, done_a, pass_a;

  logic [15:0] exp_b = 16'h0, flip_b = 16'h0;
  logic [1:0] dut_out_b, sval_b;
  logic [2:0] vec_b, svec_b, fail_b;
  logic [3:0] err_b;
  logic busy_b, vld_b, done_b, pass_b;

  int n_checks = 0, n_err = 0;
  logic cmp_on = 0, mon_b = 0;
  logic [2:0] prev_vec_b = 3'd0;

  // Circuits under test: a 2-input AND and a 2-bit identity, each with injectable per-vector output flips
  assign dut_out_a = 1'(vec_a == 2'd3) ^ flip_a[vec_a];
  assign dut_out_b = vec_b[1:0] ^ flip_b[vec_b*2 +: 2];

  always #5 clk = ~clk;

  tt_sweep_checker #(.N_IN(2), .N_OUT(1), .SETTLE(SA)) u_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .exp_table(exp_a), .dut_out(dut_out_a),
    .vec_out(vec_a), .busy(busy_a), .sample_vld(vld_a), .sample_vec(svec_a), .sample_val(sval_a),
    .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_vec(fail_a));

  tt_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .exp_table(exp_b), .dut_out(dut_out_b),
    .vec_out(vec_b), .busy(busy_b), .sample_vld(vld_b), .sample_vec(svec_b), .sample_val(sval_b),
    .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_vec(fail_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model of instance a: a sweep is a count of edges k since start; every (SA+1)th edge samples vector k/(SA+1)-1
  logic m_busy = 0, m_vld = 0, m_done = 0, m_pass = 0, m_sval = 0;
  logic [1:0] m_vec = 0, m_svec = 0, m_fail = 0;
  logic [2:0] m_err = 0;
  int m_k = 0;
  int cur_v;
  logic cur_got, cur_bad;
  assign cur_v   = (m_k + 1) / (SA + 1) - 1;
  assign cur_got = 1'(cur_v == 3) ^ flip_a[2'(cur_v)];
  assign cur_bad = cur_got != exp_a[2'(cur_v)];

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      m_busy <= 0; m_vld <= 0; m_done <= 0; m_pass <= 0; m_sval <= 0;
      m_vec <= 0; m_svec <= 0; m_fail <= 0; m_err <= 0; m_k <= 0;
    end else begin
      m_vld <= 0;
      m_done <= 0;
      if (!m_busy) begin
        if (start_a) begin
          m_busy <= 1; m_k <= 0; m_err <= 0; m_pass <= 0; m_fail <= 0; m_vec <= 0;
        end
      end else begin
        m_k <= m_k + 1;
        if ((m_k + 1) % (SA + 1) == 0) begin
          m_vld <= 1; m_svec <= 2'(cur_v); m_sval <= cur_got;
          if (cur_bad) begin
            m_err <= m_err + 3'd1;
            if (m_err == 0) m_fail <= 2'(cur_v);
          end
          if (cur_v == 3) begin
            m_busy <= 0; m_done <= 1; m_vec <= 0;
            m_pass <= (m_err == 0) && !cur_bad;
          end else begin
            m_vec <= 2'(cur_v + 1);
          end
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (cmp_on) begin
      check("a_vec_out", 32'(vec_a), 32'(m_vec));
      check("a_busy", 32'(busy_a), 32'(m_busy));
      check("a_sample_vld", 32'(vld_a), 32'(m_vld));
      check("a_sample_vec", 32'(svec_a), 32'(m_svec));
      check("a_sample_val", 32'(sval_a), 32'(m_sval));
      check("a_done", 32'(done_a), 32'(m_done));
      check("a_pass", 32'(pass_a), 32'(m_pass));
      check("a_err_cnt", 32'(err_a), 32'(m_err));
      check("a_fail_vec", 32'(fail_a), 32'(m_fail));
    end
    if (mon_b) begin
      if (vec_b !== prev_vec_b) check("b_vec_moves_on_sample", 32'(vld_b), 32'd1);
      if (vld_b) check("b_sample_val", 32'(sval_b), 32'(svec_b[1:0] ^ flip_b[svec_b*2 +: 2]));
      prev_vec_b = vec_b;
    end
  end

  function automatic logic [31:0] outs_a();
    return 32'({vec_a, busy_a, vld_a, svec_a, sval_a, done_a, pass_a, err_a, fail_a});
  endfunction

  // Start a sweep on a, optionally re-pulse start at edge pulse_at, return the edge index at which done is seen
  task automatic sweep_a(input logic [3:0] e, input int pulse_at, output int edges);
    @(negedge clk);
    exp_a = e; flip_a = 4'b0000; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == pulse_at) start_a = 1;
      if (edges == pulse_at + 1) start_a = 0;
    end while (!done_a && edges < 100);
    if (!done_a) check("a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic sweep_b(input logic [15:0] fl);
    int edges, want_err, want_fail;
    want_err = 0; want_fail = 0;
    for (int v = 7; v >= 0; v--) if (fl[v*2 +: 2] != 2'b00) begin want_err++; want_fail = v; end
    @(negedge clk);
    flip_b = fl; start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done_b && edges < 100);
    check("b_done_edge", 32'(edges), 32'd16);
    check("b_err_cnt", 32'(err_b), 32'(want_err));
    check("b_pass", 32'(pass_b), 32'(want_err == 0));
    if (want_err != 0) check("b_fail_vec", 32'(fail_b), 32'(want_fail));
  endtask

  initial begin
    int edges, hold;
    #1;
    rst_a = 0; rst_b = 0; start_a = 1;
    cmp_on = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_outputs_zero", outs_a(), 32'd0);
    end
    @(negedge clk);
    rst_a = 1; start_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_vec_out", 32'(vec_a), 32'd0);
    end

    sweep_a(4'b1000, -5, edges);
    check("and_done_edge", 32'(edges), 32'd12);
    check("and_pass", 32'(pass_a), 32'd1);
    check("and_err_cnt", 32'(err_a), 32'd0);
    check("model_pins_pass", 32'(m_pass), 32'd1);

    sweep_a(4'b1001, -5, edges);
    check("tbl1001_err_cnt", 32'(err_a), 32'd1);
    check("tbl1001_fail_vec", 32'(fail_a), 32'd0);
    check("tbl1001_pass", 32'(pass_a), 32'd0);

    sweep_a(4'b0111, -5, edges);
    check("tbl0111_err_cnt", 32'(err_a), 32'd4);
    check("tbl0111_fail_vec", 32'(fail_a), 32'd0);
    check("model_pins_err", 32'(m_err), 32'd4);

    sweep_a(4'b1000, 5, edges);
    check("start_while_busy_done_edge", 32'(edges), 32'd12);
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    check("restart_in_done_vec", 32'(vec_a), 32'd0);
    check("restart_in_done_busy", 32'(busy_a), 32'd1);
    check("restart_clears_pass", 32'(pass_a), 32'd0);
    edges = 0;
    do begin @(posedge clk); #1; edges++; end while (!done_a && edges < 100);
    check("restart_done_edge", 32'(edges), 32'd12);

    @(negedge clk);
    exp_a = 4'b1000; start_a = 1;
    @(negedge clk);
    start_a = 0;
    edges = 0;
    while (!(vld_a && svec_a == 2'd2) && edges < 100) begin @(posedge clk); #1; edges++; end
    check("reached_sample_vec2", 32'(svec_a), 32'd2);
    #2;
    rst_a = 0;
    #1;
    check("async_reset_outputs_zero", outs_a(), 32'd0);
    hold = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (done_a) hold = 1; end
    check("no_done_after_abort", 32'(hold), 32'd0);
    @(negedge clk);
    rst_a = 1;
    sweep_a(4'b1000, -5, edges);
    check("post_abort_done_edge", 32'(edges), 32'd12);
    check("post_abort_pass", 32'(pass_a), 32'd1);

    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_a) rst_a = 1;
      else if ($urandom_range(0, 299) == 0) rst_a = 0;
      if (!m_busy && $urandom_range(0, 2) == 0) begin
        exp_a  = 4'($urandom);
        flip_a = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      end
      if (i % 500 == 0) hold = ($urandom_range(0, 2) == 0);
      start_a = hold ? 1'b1 : ($urandom_range(0, 9) < 2);
    end
    @(negedge clk);
    start_a = 0; rst_a = 1;

    exp_b = 16'h0;
    for (int v = 0; v < 8; v++) exp_b[v*2 +: 2] = 2'(v);
    @(negedge clk);
    rst_b = 1;
    @(posedge clk); #1;
    prev_vec_b = vec_b;
    mon_b = 1;
    sweep_b(16'h0000);
    check("identity_pass", 32'(pass_b), 32'd1);
    sweep_b(16'h0300);
    check("identity_fail_vec4", 32'(fail_b), 32'd4);
    for (int i = 0; i < 6; i++) sweep_b(16'($urandom) & 16'($urandom) & 16'($urandom));

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
